ball_engine: RTL

- Parametrised ball-physics engine, successor to the single-ball logic inside the game logic.
- Moves N_BALLS balls with sub-pixel fixed-point positions, one update per new_frame_i.
- Handles wall bounce, paddle-hit deflection with speed-up, goal detection and a timed serve per ball.
- Sits between the sprite collision units, which drive hit_*_i, and the sprite/score logic, which consumes the positions and goal pulses.

---
 rtl/ball_engine.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ball_engine.sv
// Multi-ball physics engine: sub-pixel motion, wall and paddle deflection,
// goal detection and a timed serve, one position update per frame strobe.
module ball_engine #(
    parameter int N_BALLS       = 2,
    parameter int X_POS_W       = 10,
    parameter int Y_POS_W       = 10,
    parameter int FRAC_W        = 4,
    parameter int SPEED_W       = 8,
    parameter int SCREEN_H_RES  = 640,
    parameter int SCREEN_V_RES  = 480,
    parameter int SCREEN_BORDER = 5,
    parameter int BALL_SIDE     = 8,
    parameter int SERVE_FRAMES  = 60,
    parameter int SERVE_SPEED   = 32,
    parameter int SPEEDUP_STEP  = 4,
    parameter int MAX_SPEED     = 96
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         new_frame_i,
    input  logic [8:0]                   rnd_i,
    input  logic [N_BALLS-1:0]           hit_left_i,
    input  logic [N_BALLS-1:0]           hit_right_i,
    output logic [N_BALLS*X_POS_W-1:0]   x_pos_o,
    output logic [N_BALLS*Y_POS_W-1:0]   y_pos_o,
    output logic [N_BALLS-1:0]           active_o,
    output logic [N_BALLS-1:0]           goal_left_o,
    output logic [N_BALLS-1:0]           goal_right_o
);

    localparam int XW    = X_POS_W + FRAC_W;
    localparam int YW    = Y_POS_W + FRAC_W;
    localparam int PW    = (XW > YW) ? XW : YW;
    localparam int MAG_W = SPEED_W - 1;
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [XW-1:0]      X_CENTRE = XW'(SCREEN_H_RES / 2) << FRAC_W;
    localparam logic [YW-1:0]      Y_CENTRE = YW'(SCREEN_V_RES / 2) << FRAC_W;
    localparam logic [X_POS_W-1:0] GOAL_L   = X_POS_W'(SCREEN_BORDER);
    localparam logic [X_POS_W-1:0] GOAL_R   = X_POS_W'(SCREEN_H_RES - SCREEN_BORDER);
    localparam logic [Y_POS_W-1:0] WALL_TOP = Y_POS_W'(SCREEN_BORDER);
    localparam logic [Y_POS_W:0]   WALL_BOT = (Y_POS_W + 1)'(SCREEN_V_RES - SCREEN_BORDER);
    localparam logic [Y_POS_W:0]   SIDE     = (Y_POS_W + 1)'(BALL_SIDE);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, GOAL} state_t;

    // Moves one axis by a sign-magnitude step; going below zero clamps to zero.
    function automatic logic [PW-1:0] sat_step(input logic [PW-1:0] pos,
                                               input logic neg,
                                               input logic [MAG_W-1:0] mag);
        logic signed [PW+1:0] acc;
        logic signed [PW+1:0] delta;
        acc   = $signed({2'b00, pos});
        delta = $signed({{(PW + 2 - MAG_W){1'b0}}, mag});
        acc   = neg ? (acc - delta) : (acc + delta);
        return (acc < 0) ? '0 : acc[PW-1:0];
    endfunction

    function automatic logic [MAG_W-1:0] speed_up(input logic [MAG_W-1:0] mag);
        logic [MAG_W:0] sum;
        sum = {1'b0, mag} + (MAG_W + 1)'(SPEEDUP_STEP);
        return (sum > (MAG_W + 1)'(MAX_SPEED)) ? MAG_W'(MAX_SPEED) : sum[MAG_W-1:0];
    endfunction

    logic unused_rnd;
    assign unused_rnd = ^rnd_i[8:5];

    for (genvar gi = 0; gi < N_BALLS; gi++) begin : g_ball
        localparam logic PARITY = ((gi % 2) == 1);

        state_t             state_q, state_n;
        logic [XW-1:0]      x_q, x_n;
        logic [YW-1:0]      y_q, y_n;
        logic               xs_q, xs_n, ys_q, ys_n;
        logic [MAG_W-1:0]   xm_q, xm_n, ym_q, ym_n;
        logic [CNT_W-1:0]   cnt_q, cnt_n;
        logic               hl_q, hl_n, hr_q, hr_n;
        logic               gl_q, gl_n, gr_q, gr_n;
        logic               hit_l, hit_r;
        logic [X_POS_W-1:0] x_int;
        logic [Y_POS_W-1:0] y_int;

        assign x_int = x_q[XW-1:FRAC_W];
        assign y_int = y_q[YW-1:FRAC_W];
        assign hit_l = hl_q | hit_left_i[gi];
        assign hit_r = hr_q | hit_right_i[gi];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                x_q     <= X_CENTRE;
                y_q     <= Y_CENTRE;
                xs_q    <= 1'b0;
                ys_q    <= 1'b0;
                xm_q    <= '0;
                ym_q    <= '0;
                cnt_q   <= '0;
                hl_q    <= 1'b0;
                hr_q    <= 1'b0;
                gl_q    <= 1'b0;
                gr_q    <= 1'b0;
            end else begin
                state_q <= state_n;
                x_q     <= x_n;
                y_q     <= y_n;
                xs_q    <= xs_n;
                ys_q    <= ys_n;
                xm_q    <= xm_n;
                ym_q    <= ym_n;
                cnt_q   <= cnt_n;
                hl_q    <= hl_n;
                hr_q    <= hr_n;
                gl_q    <= gl_n;
                gr_q    <= gr_n;
            end
        end

        always_comb begin
            state_n = state_q;
            x_n     = x_q;
            y_n     = y_q;
            xs_n    = xs_q;
            ys_n    = ys_q;
            xm_n    = xm_q;
            ym_n    = ym_q;
            cnt_n   = cnt_q;
            hl_n    = hl_q;
            hr_n    = hr_q;
            gl_n    = 1'b0;
            gr_n    = 1'b0;

            if (!enable_i) begin
                state_n = IDLE;
                x_n     = X_CENTRE;
                y_n     = Y_CENTRE;
                xs_n    = 1'b0;
                ys_n    = 1'b0;
                xm_n    = '0;
                ym_n    = '0;
                cnt_n   = '0;
                hl_n    = 1'b0;
                hr_n    = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_n = SERVE;
                        cnt_n   = '0;
                    end
                    SERVE: begin
                        if (new_frame_i) begin
                            if (cnt_q == CNT_LAST) begin
                                state_n = PLAY;
                                xs_n    = rnd_i[0] ^ PARITY;
                                xm_n    = MAG_W'(SERVE_SPEED);
                                ys_n    = rnd_i[1];
                                ym_n    = MAG_W'({rnd_i[4:2], 2'b00});
                            end else begin
                                cnt_n = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    PLAY: begin
                        if (!new_frame_i) begin
                            hl_n = hit_l;
                            hr_n = hit_r;
                        end else if (x_int < GOAL_L || x_int > GOAL_R) begin
                            // Goal is judged on the pre-update position and overrides any hit.
                            state_n = GOAL;
                            gl_n    = (x_int < GOAL_L);
                            gr_n    = !(x_int < GOAL_L);
                            x_n     = X_CENTRE;
                            y_n     = Y_CENTRE;
                            xs_n    = 1'b0;
                            ys_n    = 1'b0;
                            xm_n    = '0;
                            ym_n    = '0;
                            hl_n    = 1'b0;
                            hr_n    = 1'b0;
                        end else begin
                            if (hit_l && !hit_r) begin
                                xs_n = 1'b0;
                                xm_n = speed_up(xm_q);
                            end else if (hit_r && !hit_l) begin
                                xs_n = 1'b1;
                                xm_n = speed_up(xm_q);
                            end
                            if (y_int < WALL_TOP && ys_q) begin
                                ys_n = 1'b0;
                            end else if (({1'b0, y_int} + SIDE) > WALL_BOT && !ys_q) begin
                                ys_n = 1'b1;
                            end
                            x_n  = XW'(sat_step(PW'(x_q), xs_n, xm_n));
                            y_n  = YW'(sat_step(PW'(y_q), ys_n, ym_n));
                            hl_n = 1'b0;
                            hr_n = 1'b0;
                        end
                    end
                    GOAL: begin
                        state_n = SERVE;
                        cnt_n   = '0;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end

        assign x_pos_o[gi*X_POS_W +: X_POS_W] = x_int;
        assign y_pos_o[gi*Y_POS_W +: Y_POS_W] = y_int;
        assign active_o[gi]     = (state_q == PLAY);
        assign goal_left_o[gi]  = gl_q;
        assign goal_right_o[gi] = gr_q;
    end

endmodule
